// File: rtl/mosq_pkg.sv
// rtl/mosq_pkg.sv - shared types, defaults and helpers for the mosquito detector
package mosq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_DET  = 2'd2
    } mosq_state_e;

    localparam int ON_THRESH = 10;
    localparam int HOLD_LEN  = 500;

    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/mosq_detector_mc_if.sv
// rtl/mosq_detector_mc_if.sv - sample/config inputs and detection outputs of the detector
interface mosq_detector_mc_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 5,
    parameter int HOLD_W = 9,
    parameter int EVT_W  = 16
);
    logic              in_en;
    logic [NUM_CH-1:0] is_large;
    logic [CNT_W-1:0]  on_thresh;
    logic [HOLD_W-1:0] hold_len;
    logic              clr_evt;
    logic [NUM_CH-1:0] is_mosq;
    logic [NUM_CH-1:0] mosq_rise;
    logic [NUM_CH-1:0] mosq_fall;
    logic              any_mosq;
    logic [EVT_W-1:0]  evt_cnt;

    modport master (
        output in_en, is_large, on_thresh, hold_len, clr_evt,
        input  is_mosq, mosq_rise, mosq_fall, any_mosq, evt_cnt
    );

    modport slave (
        input  in_en, is_large, on_thresh, hold_len, clr_evt,
        output is_mosq, mosq_rise, mosq_fall, any_mosq, evt_cnt
    );
endinterface

// File: rtl/mosq_channel.sv
// rtl/mosq_channel.sv - one channel: run qualification, hold timer, flag and edge pulses
module mosq_channel
    import mosq_pkg::*;
#(
    parameter int CNT_W  = 5,
    parameter int HOLD_W = 9,
    parameter bit RETRIG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_en,
    input  logic              is_large,
    input  logic [CNT_W-1:0]  on_thresh,
    input  logic [HOLD_W-1:0] hold_len,
    output logic              is_mosq,
    output logic              mosq_rise,
    output logic              mosq_fall,
    output logic              rise_next
);

    localparam logic [31:0] RUN_MAX  = (32'd1 << CNT_W) - 32'd1;
    localparam logic [31:0] HOLD_MAX = (32'd1 << HOLD_W) - 32'd1;

    mosq_state_e       state_q, state_d;
    logic [CNT_W-1:0]  run_q, run_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              flag_q, flag_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic [31:0]       thr, hlen, run_inc, hold_inc;

    always_comb begin
        // zero thresholds behave as one so a channel can never stall in ARM or DET
        thr      = (on_thresh == '0) ? 32'd1 : 32'(on_thresh);
        hlen     = (hold_len == '0) ? 32'd1 : 32'(hold_len);
        run_inc  = sat_inc(32'(run_q), RUN_MAX);
        hold_inc = sat_inc(32'(hold_q), HOLD_MAX);
        state_d  = state_q;
        run_d    = run_q;
        hold_d   = hold_q;
        flag_d   = flag_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (in_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (is_large) begin
                        run_d = CNT_W'(1);
                        if (thr <= 32'd1) begin
                            state_d = ST_DET;
                            hold_d  = '0;
                            flag_d  = 1'b1;
                            rise_d  = 1'b1;
                        end else begin
                            state_d = ST_ARM;
                        end
                    end
                end
                ST_ARM: begin
                    if (is_large) begin
                        run_d = CNT_W'(run_inc);
                        if (32'(run_q) + 32'd1 >= thr) begin
                            state_d = ST_DET;
                            hold_d  = '0;
                            flag_d  = 1'b1;
                            rise_d  = 1'b1;
                        end
                    end else begin
                        run_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
                ST_DET: begin
                    if (is_large && RETRIG) begin
                        hold_d = '0;
                    end else begin
                        hold_d = HOLD_W'(hold_inc);
                        if (32'(hold_q) + 32'd1 >= hlen) begin
                            state_d = ST_IDLE;
                            run_d   = '0;
                            flag_d  = 1'b0;
                            fall_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    run_d   = '0;
                    hold_d  = '0;
                    flag_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            run_q   <= '0;
            hold_q  <= '0;
            flag_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            hold_q  <= hold_d;
            flag_q  <= flag_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign is_mosq   = flag_q;
    assign mosq_rise = rise_q;
    assign mosq_fall = fall_q;
    assign rise_next = rise_d & ~rst;

endmodule

// File: rtl/mosq_detector_mc.sv
// rtl/mosq_detector_mc.sv - multi-channel mosquito detector with any-flag and event counter
module mosq_detector_mc
    import mosq_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 5,
    parameter int HOLD_W = 9,
    parameter int EVT_W  = 16,
    parameter bit RETRIG = 1'b1
) (
    input logic               clk,
    input logic               rst,
    mosq_detector_mc_if.slave bus
);

    logic [NUM_CH-1:0] flag, rise, fall, rise_next;
    logic [EVT_W-1:0]  evt_q, evt_d;
    logic [EVT_W:0]    rise_cnt, evt_sum;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        mosq_channel #(
            .CNT_W  (CNT_W),
            .HOLD_W (HOLD_W),
            .RETRIG (RETRIG)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .in_en     (bus.in_en),
            .is_large  (bus.is_large[i]),
            .on_thresh (bus.on_thresh),
            .hold_len  (bus.hold_len),
            .is_mosq   (flag[i]),
            .mosq_rise (rise[i]),
            .mosq_fall (fall[i]),
            .rise_next (rise_next[i])
        );
    end

    // rises are counted on the same edge that registers their pulses
    always_comb begin
        rise_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rise_cnt = rise_cnt + (EVT_W+1)'(rise_next[i]);
        end
        evt_sum = {1'b0, evt_q} + rise_cnt;
        if (bus.clr_evt) begin
            evt_d = EVT_W'(rise_cnt);
        end else if (evt_sum[EVT_W]) begin
            evt_d = {EVT_W{1'b1}};
        end else begin
            evt_d = evt_sum[EVT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_q <= '0;
        end else begin
            evt_q <= evt_d;
        end
    end

    assign bus.is_mosq   = flag;
    assign bus.mosq_rise = rise;
    assign bus.mosq_fall = fall;
    assign bus.any_mosq  = |flag;
    assign bus.evt_cnt   = evt_q;

endmodule
